mmcm_drp_responder: RTL and testbench

Synthesizable DRP responder that emulates the MMCM_ADV dynamic reconfiguration port and LOCKED behaviour. It sits on the target side of the DRP link, so the mmcm_drp reconfiguration controller can be exercised on hardware or in simulation without a real MMCM primitive. It holds a 128 x 16 register space, answers DEN/DWE transactions with a configurable DRDY latency, and models loss and reacquisition of lock around RST_MMCM. Protocol violations are reported on sticky error flags.

---
 rtl/mmcm_drp_responder.sv | 178 +++++++++++++++++
 tb/tb_mmcm_drp_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_responder.sv
// rtl/mmcm_drp_responder.sv - DRP target that emulates an MMCM_ADV register port and LOCKED
//
// Stands in for a real MMCM primitive on the target side of a DRP link, so a
// reconfiguration controller can be exercised without one. Holds a 128 x 16
// register space that is zeroed after every RST. Each DEN is answered with a
// single DRDY pulse DRDY_LATENCY cycles later. LOCKED is emulated as a counter
// that restarts whenever RST_MMCM is high.
//
// Parameters:
//   DRDY_LATENCY  cycles from the DEN cycle to the DRDY cycle (1..15)
//   LOCK_DELAY    cycles of RST_MMCM=0 after the clear until LOCKED (1..65535)
//
// Ports:
//   DCLK      in   DRP clock; all state changes on its rising edge
//   RST       in   synchronous active-high reset
//   DEN       in   transaction strobe, one cycle per transaction
//   DWE       in   1 = write, 0 = read; sampled with DEN
//   DADDR     in   [6:0] register address; sampled with DEN
//   DI        in   [15:0] write data; sampled with DEN
//   DO        out  [15:0] read data while DRDY=1, zero otherwise
//   DRDY      out  single-cycle completion pulse
//   RST_MMCM  in   emulated MMCM reset, active high
//   LOCKED    out  emulated lock indication
//   BUSY      out  high while the register space is being cleared
//   ERR       out  [1:0] sticky: [0] DEN not accepted, [1] write committed while RST_MMCM=0

module mmcm_drp_responder #(
  parameter int DRDY_LATENCY = 4,
  parameter int LOCK_DELAY   = 64
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [6:0]  DADDR,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  input  logic        RST_MMCM,
  output logic        LOCKED,
  output logic        BUSY,
  output logic [1:0]  ERR
);

  // The counter is loaded with LATENCY-1. DRDY is asserted while the counter reads zero in
  // WAIT, which places DRDY exactly DRDY_LATENCY cycles after the DEN cycle.
  localparam logic [3:0]  LAT_LOAD = 4'(DRDY_LATENCY - 1);
  localparam logic [15:0] LOCK_MAX = 16'(LOCK_DELAY);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  lat_cnt;
  logic [6:0]  clr_addr;
  logic        cap_we;
  logic [6:0]  cap_addr;
  logic [15:0] cap_data;
  logic [15:0] lock_cnt;
  logic [15:0] mem [128];

  logic        accept;
  logic        ignored;
  logic        commit;
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [15:0] mem_wdata;

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    DRDY       = 1'b0;
    BUSY       = 1'b0;
    accept     = 1'b0;
    ignored    = 1'b0;
    case (state)
      ST_CLEAR: begin
        BUSY    = 1'b1;
        ignored = DEN;
        if (clr_addr == 7'd127) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (DEN) begin
          accept     = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == 4'd0) begin
          // The DRDY cycle also acts as IDLE, so a DEN here starts the next transaction.
          DRDY = 1'b1;
          if (DEN) begin
            accept     = 1'b1;
            state_next = ST_WAIT;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          ignored = DEN;
        end
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  // A write lands in memory on the edge that ends its DRDY cycle.
  assign commit    = DRDY & cap_we;
  assign mem_we    = BUSY | commit;
  assign mem_waddr = BUSY ? clr_addr : cap_addr;
  assign mem_wdata = BUSY ? 16'h0000 : cap_data;

  assign DO     = (DRDY && !cap_we) ? mem[cap_addr] : 16'h0000;
  assign LOCKED = (lock_cnt == LOCK_MAX);

  always_ff @(posedge DCLK) begin
    if (RST) begin
      lat_cnt  <= 4'd0;
      clr_addr <= 7'd0;
      cap_we   <= 1'b0;
      cap_addr <= 7'd0;
      cap_data <= 16'h0000;
      ERR      <= 2'b00;
      lock_cnt <= 16'd0;
    end else begin
      // Wraps back to 0 on the last clear cycle, ready for the next reset.
      if (BUSY) begin
        clr_addr <= clr_addr + 7'd1;
      end

      if (accept) begin
        cap_we   <= DWE;
        cap_addr <= DADDR;
        cap_data <= DI;
        lat_cnt  <= LAT_LOAD;
      end else if (state == ST_WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      if (ignored) begin
        ERR[0] <= 1'b1;
      end
      if (commit && !RST_MMCM) begin
        ERR[1] <= 1'b1;
      end

      // Any cycle with RST_MMCM high, however short, restarts the full lock count.
      if (RST_MMCM || BUSY) begin
        lock_cnt <= 16'd0;
      end else if (lock_cnt != LOCK_MAX) begin
        lock_cnt <= lock_cnt + 16'd1;
      end
    end
  end

  // No reset on the array, so it can map onto RAM; CLEAR zeroes it instead.
  always_ff @(posedge DCLK) begin
    if (!RST && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mmcm_drp_responder.sv
// tb/tb_mmcm_drp_responder.sv - self-checking bench for mmcm_drp_responder

module tb_mmcm_drp_responder;

  logic        DCLK;
  logic        RST;
  logic        DEN;
  logic        DWE;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;
  logic        RST_MMCM;
  logic        LOCKED;
  logic        BUSY;
  logic [1:0]  ERR;

  mmcm_drp_responder #(
    .DRDY_LATENCY(4),
    .LOCK_DELAY  (64)
  ) dut (
    .DCLK    (DCLK),
    .RST     (RST),
    .DEN     (DEN),
    .DWE     (DWE),
    .DADDR   (DADDR),
    .DI      (DI),
    .DO      (DO),
    .DRDY    (DRDY),
    .RST_MMCM(RST_MMCM),
    .LOCKED  (LOCKED),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  always @(posedge DCLK) cyc <= cyc + 1;

  // Scoreboard: every DRDY must match the oldest pending expectation in data and cycle.
  always @(negedge DCLK) begin
    if (DRDY === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL drdy_unexpected: DRDY=1 at cycle %0d with DO=%h, required no DRDY", cyc, DO);
      end else begin
        e = sb.pop_front();
        if (DO !== e.data) begin
          fails++;
          $display("FAIL drdy_data: DO=%h, required %h (cycle %0d)", DO, e.data, cyc);
        end
        tests++;
        if (cyc !== e.cyc) begin
          fails++;
          $display("FAIL drdy_latency: DRDY at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
      end
    end else begin
      tests++;
      if (DO !== 16'h0000) begin
        fails++;
        $display("FAIL do_idle: DO=%h while DRDY=%b, required 0000", DO, DRDY);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  task automatic drp(input logic we, input logic [6:0] a, input logic [15:0] d,
                     input logic [15:0] exp_do);
    DEN   = 1'b1;
    DWE   = we;
    DADDR = a;
    DI    = d;
    sb.push_back('{exp_do, cyc + 4});
    tick();
    DEN = 1'b0;
    DWE = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drdy_timeout: %0d transactions pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (BUSY !== 1'b0) begin
      fails++;
      $display("FAIL busy_timeout: BUSY=%b, required 0", BUSY);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    int t_fall;
    RST = 1'b1; RST_MMCM = 1'b0; DEN = 1'b0; DWE = 1'b0; DADDR = 7'd0; DI = 16'h0000;
    repeat (3) tick();
    tests++; if (DO !== 16'h0000) begin fails++; $display("FAIL reset_do: DO=%h, required 0000", DO); end
    tests++; if (DRDY !== 1'b0) begin fails++; $display("FAIL reset_drdy: DRDY=%b, required 0", DRDY); end
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL reset_locked: LOCKED=%b, required 0", LOCKED); end
    tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL reset_busy: BUSY=%b, required 1", BUSY); end
    tests++; if (ERR !== 2'b00) begin fails++; $display("FAIL reset_err: ERR=%b, required 00", ERR); end
    RST = 1'b0;
    while (BUSY === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    tests++;
    if (n !== 128) begin
      fails++;
      $display("FAIL busy_length: BUSY high %0d cycles, required 128", n);
    end
    t_fall = cyc;
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL lock_at_clear_end: LOCKED=%b, required 0", LOCKED); end
    drp(1'b0, 7'h28, 16'h0000, 16'h0000);
    wait_idle();
    while (LOCKED !== 1'b1 && (cyc - t_fall) < 200) tick();
    tests++;
    if ((cyc - t_fall) !== 64) begin
      fails++;
      $display("FAIL lock_delay: LOCKED rose %0d cycles after BUSY fell, required 64", cyc - t_fall);
    end
  endtask

  task automatic test_write_read();
    RST_MMCM = 1'b1;
    tick();
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL lock_drop: LOCKED=%b, required 0", LOCKED); end
    drp(1'b1, 7'h08, 16'h1041, 16'h0000);
    wait_idle();
    drp(1'b0, 7'h08, 16'h0000, 16'h1041);
    wait_idle();
    tests++; if (ERR !== 2'b00) begin fails++; $display("FAIL wr_rd_err: ERR=%b, required 00", ERR); end
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL wr_rd_locked: LOCKED=%b, required 0", LOCKED); end
  endtask

  task automatic test_overlap();
    drp(1'b0, 7'h08, 16'h0000, 16'h1041);
    tick();
    // Second DEN two cycles later must be dropped; the monitor flags any extra DRDY.
    DEN = 1'b1; DWE = 1'b0; DADDR = 7'h30;
    tick();
    DEN = 1'b0;
    wait_idle();
    repeat (8) tick();
    tests++; if (ERR !== 2'b01) begin fails++; $display("FAIL overlap_err: ERR=%b, required 01", ERR); end
  endtask

  task automatic test_back_to_back();
    drp(1'b1, 7'h10, 16'h5A5A, 16'h0000);
    repeat (3) tick();
    tests++; if (DRDY !== 1'b1) begin fails++; $display("FAIL b2b_first_drdy: DRDY=%b, required 1", DRDY); end
    drp(1'b0, 7'h10, 16'h0000, 16'h5A5A);
    wait_idle();
    drp(1'b1, 7'h11, 16'h0F0F, 16'h0000);
    repeat (3) tick();
    drp(1'b0, 7'h11, 16'h0000, 16'h0F0F);
    wait_idle();
  endtask

  task automatic test_unlocked_write();
    int n = 0;
    int t1;
    RST_MMCM = 1'b0;
    tick();
    tests++; if (ERR[1] !== 1'b0) begin fails++; $display("FAIL unlk_err_pre: ERR[1]=%b, required 0", ERR[1]); end
    drp(1'b1, 7'h14, 16'hABCD, 16'h0000);
    repeat (3) tick();
    tests++; if (DRDY !== 1'b1) begin fails++; $display("FAIL unlk_drdy: DRDY=%b, required 1", DRDY); end
    tests++; if (ERR[1] !== 1'b0) begin fails++; $display("FAIL unlk_err_early: ERR[1]=%b, required 0", ERR[1]); end
    tick();
    tests++; if (ERR !== 2'b11) begin fails++; $display("FAIL unlk_err_commit: ERR=%b, required 11", ERR); end
    wait_idle();
    drp(1'b0, 7'h14, 16'h0000, 16'hABCD);
    wait_idle();
    while (LOCKED !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tests++; if (LOCKED !== 1'b1) begin fails++; $display("FAIL relock: LOCKED=%b, required 1", LOCKED); end
    RST_MMCM = 1'b1;
    tick();
    RST_MMCM = 1'b0;
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL pulse_drop: LOCKED=%b, required 0", LOCKED); end
    t1 = cyc;
    while (LOCKED !== 1'b1 && (cyc - t1) < 200) tick();
    tests++;
    if ((cyc - t1) !== 64) begin
      fails++;
      $display("FAIL pulse_relock: LOCKED returned after %0d cycles, required 64", cyc - t1);
    end
  endtask

  task automatic test_reset_mid_op();
    DEN = 1'b1; DWE = 1'b0; DADDR = 7'h08;
    tick();
    DEN = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    tests++; if (DRDY !== 1'b0) begin fails++; $display("FAIL midop_drdy: DRDY=%b, required 0", DRDY); end
    tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL midop_busy: BUSY=%b, required 1", BUSY); end
    tests++; if (ERR !== 2'b00) begin fails++; $display("FAIL midop_err: ERR=%b, required 00", ERR); end
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL midop_locked: LOCKED=%b, required 0", LOCKED); end
    tick();
    RST = 1'b0;
    DEN = 1'b1; DWE = 1'b0; DADDR = 7'h08;
    tick();
    DEN = 1'b0;
    tests++; if (ERR !== 2'b01) begin fails++; $display("FAIL clear_den_err: ERR=%b, required 01", ERR); end
    wait_not_busy();
    drp(1'b0, 7'h08, 16'h0000, 16'h0000);
    wait_idle();
    drp(1'b0, 7'h14, 16'h0000, 16'h0000);
    wait_idle();
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_overlap();
    test_back_to_back();
    test_unlocked_write();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
